// File: rtl/display_pkg.sv
// display_pkg: shared types and constants for the binary-to-BCD display path.
package display_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, FIN} b2b_state_t;
    localparam int NDIG = 8;
    localparam logic [26:0] MAX_DEC = 27'd99_999_999;
    localparam logic [3:0] OVF_DIGIT = 4'hE;
endpackage

// File: rtl/bin_to_bcd_display_dd_adjust.sv
// dd_adjust: double-dabble nibble correction, adds 3 to any digit of 5 or more.
module dd_adjust (
    input  logic [3:0] n,
    output logic [3:0] y
);
    assign y = n >= 4'd5 ? n + 4'd3 : n;
endmodule

// File: rtl/bin_to_bcd_display.sv
// bin_to_bcd_display: iterative double-dabble converter feeding the seven-segment decoder.
module bin_to_bcd_display
    import display_pkg::*;
#(
    parameter int BIN_W = 27
) (
    input  logic                 hz100,
    input  logic                 reset,
    input  logic                 start,
    input  logic [BIN_W-1:0]     value,
    input  logic                 dp_en,
    input  logic [2:0]           dp_pos,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf,
    output logic [NDIG-1:0][3:0] digits,
    output logic [7:0]           flt_pt
);
    localparam int CW = $clog2(BIN_W + 1);
    localparam int PW = 4 * NDIG + BIN_W;

    b2b_state_t           state, state_n;
    logic [BIN_W-1:0]     shift_q;
    logic [NDIG-1:0][3:0] scr_q, adj;
    logic [CW-1:0]        cnt;
    logic                 dp_en_q, big_q;
    logic [2:0]           dp_pos_q;
    logic [PW-1:0]        pair_sh;

    for (genvar i = 0; i < NDIG; i++) begin : g_adj
        dd_adjust u_adj (.n(scr_q[i]), .y(adj[i]));
    end

    always_comb begin
        pair_sh = {adj, shift_q} << 1;
        state_n = state == IDLE  ? (start ? SHIFT : IDLE) :
                  state == SHIFT ? (cnt == CW'(1) ? FIN : SHIFT) : IDLE;
    end

    // Outputs are loaded on the last shift edge so they are already valid while done is high.
    always_ff @(posedge hz100) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            digits   <= '0;
            flt_pt   <= '0;
            shift_q  <= '0;
            scr_q    <= '0;
            cnt      <= '0;
            dp_en_q  <= 1'b0;
            dp_pos_q <= '0;
            big_q    <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= state_n != IDLE;
            done  <= state_n == FIN;
            if (state == IDLE && start) begin
                shift_q  <= value;
                scr_q    <= '0;
                cnt      <= CW'(BIN_W);
                dp_en_q  <= dp_en;
                dp_pos_q <= dp_pos;
                big_q    <= 27'(value) > MAX_DEC;
            end
            if (state == SHIFT) begin
                {scr_q, shift_q} <= pair_sh;
                cnt              <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    digits <= big_q ? {NDIG{OVF_DIGIT}} : pair_sh[PW-1 -: 4*NDIG];
                    flt_pt <= dp_en_q ? 8'b1 << dp_pos_q : 8'h00;
                    ovf    <= big_q;
                end
            end
        end
    end
endmodule
